led7seg_scan: RTL
=================

// Module: led7seg_scan
// PURPOSE
//  Upstream feeder for the single-digit 7-seg decoder: time-multiplexes a 16-bit hex value over 4 digits.
//  Each slot drives one nibble on NIB (to decoder input I) and pulls that digit's select line SA low.
//  Adds anti-ghost blanking gap, leading-zero blanking and a frame-synchronous value load.
// PARAMETERS
//  SLOT_CYC  50000  clock cycles per digit slot (gap + show); must be > GAP_CYC
//  GAP_CYC   500    cycles at the start of each slot with all SA released (Z); must be >= 1
//  LZB       1      1 = blank leading zero digits 3..1 (digit 0 always shown); 0 = show all
// PORTS
//  CLK    in   1   system clock, all logic on rising edge
//  RST_N  in   1   synchronous reset, active low
//  D_IN   in   16  new display value, D_IN[3:0] = digit 0 (rightmost)
//  LOAD   in   1   1-cycle strobe: capture D_IN into pending register
//  NIB    out  4   nibble for current digit, drives decoder I
//  SA     out  4   digit selects, active low; inactive = Z; at most one bit 0
//  FRAME  out  1   1-cycle pulse at start of each frame (first GAP cycle of digit 0)
//  PEND   out  1   1 = loaded value waiting for next frame boundary
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): VAL=0, PVAL=0, PEND=0, idx=0, state=GAP, cnt=0;
//    NIB=0, SA=4'bZZZZ, FRAME=0. Post-reset frame emits no FRAME pulse.
//  - All outputs registered. State machine per slot:
//    GAP : cnt 0..GAP_CYC-1, SA=ZZZZ, NIB=VAL[4*idx+:4]
//    SHOW: cnt GAP_CYC..SLOT_CYC-1, SA[idx]=0 others Z (unless blanked), NIB unchanged
//    SHOW at cnt=SLOT_CYC-1 -> GAP, cnt=0, idx=idx+1 mod 4 (3 wraps to 0).
//  - Frame = 4*SLOT_CYC cycles, constant; blanking never changes timing.
//  - Frame boundary = edge where idx wraps 3->0. On that edge: if PEND, VAL<=PVAL, PEND<=0;
//    FRAME=1 for the following single cycle.
//  - LOAD=1: PVAL<=D_IN, PEND<=1. Repeated LOADs before boundary: last wins.
//  - LOAD on boundary edge: VAL takes old PVAL (if PEND), PVAL<=D_IN, PEND stays 1.
//  - NIB and blanking use VAL only; VAL never changes mid-frame.
//  - Leading-zero blank (LZB=1): digit k (k=1..3) suppressed if VAL[15:4k]==0;
//    suppressed digit keeps SA=ZZZZ for its whole slot, NIB still driven.
//  - Reset mid-frame: immediate return to reset values next cycle; pending load discarded.
//  - cnt width = $clog2(SLOT_CYC); no other arithmetic.
// STRUCTURE
//  - Shared package: state encoding (ST_GAP, ST_SHOW), SA_OFF = 4'bZZZZ, NDIG = 4.
//  - One sub-module: led7seg_slot_timer (cnt, GAP/SHOW state, idx, slot_end/frame_end strobes).
//  - Top: VAL/PVAL/PEND registers, nibble mux, zero-blank compare, SA/NIB/FRAME output regs.
// TESTING (SLOT_CYC=8, GAP_CYC=2, LZB=1 unless noted)
//  1 Reset: hold RST_N=0 3 cycles -> NIB=0, SA=ZZZZ, FRAME=0, PEND=0; release -> SA[0]=0 from cycle 2-7 of slot 0.
//  2 LOAD D_IN=16'h1234 mid-frame -> PEND=1, NIB stays 0 until boundary; next frame NIB=4,3,2,1,
//    SA=ZZZ0,ZZ0Z,Z0ZZ,0ZZZ each for 6 show cycles after 2 gap cycles; FRAME 1 cycle every 32.
//  3 LOAD 16'h0050 -> digits 3,2 SA stay ZZZZ all slot, digit 1 shows 5, digit 0 shows 0;
//    LZB=0 rerun -> all four digits selected.
//  4 LOAD 16'hAAAA then 16'hBBBB same frame -> next frame shows B on all digits.
//  5 LOAD 16'hCCCC exactly on boundary edge with PEND=1 (PVAL=16'h1111) -> frame shows 1111,
//    PEND=1, following frame shows CCCC.
//  6 RST_N=0 during SHOW of digit 2 with PEND=1 -> next cycle reset values, PEND=0, VAL=0.

Source files
------------

// File: rtl/led7seg_scan_pkg.sv
// Shared types and constants for the 4-digit 7-segment scanner.
package led7seg_scan_pkg;

  localparam int unsigned NDIG = 4;
  localparam logic [3:0] SA_OFF = 4'bzzzz;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } slot_state_t;

  typedef logic [1:0] dig_idx_t;

  // Digit 0 is always lit; digit k>0 is lit unless every nibble from k upward is zero.
  function automatic logic digit_lit(input logic [15:0] v, input dig_idx_t k, input logic lzb);
    logic lit;
    case (k)
      2'd1:    lit = (v[15:4] != 12'h000);
      2'd2:    lit = (v[15:8] != 8'h00);
      2'd3:    lit = (v[15:12] != 4'h0);
      default: lit = 1'b1;
    endcase
    return lit | ~lzb;
  endfunction

endpackage

// File: rtl/led7seg_scan_slot_timer.sv
// Slot/frame timing: per-slot counter, GAP/SHOW phase and digit index.
module led7seg_scan_slot_timer
  import led7seg_scan_pkg::*;
#(
  parameter int unsigned SLOT_CYC = 50000,
  parameter int unsigned GAP_CYC  = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  output slot_state_t state_nxt,
  output dig_idx_t    idx_nxt,
  output logic        frame_end
);

  localparam int unsigned CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);

  slot_state_t   state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  dig_idx_t      idx;
  logic          slot_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_GAP;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    case (state)
      ST_GAP: begin
        if (cnt == GAP_LAST) state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        if (slot_end) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: state_nxt = ST_GAP;
    endcase
  end

  always_comb begin
    slot_end  = (state == ST_SHOW) && (cnt == SLOT_LAST);
    frame_end = slot_end && (idx == 2'd3);
  end

endmodule

// File: rtl/led7seg_scan.sv
// Time-multiplexes a 16-bit hex value over 4 digits with gap blanking,
// leading-zero blanking and a frame-synchronous value load.
module led7seg_scan
  import led7seg_scan_pkg::*;
#(
  parameter int unsigned SLOT_CYC = 50000,
  parameter int unsigned GAP_CYC  = 500,
  parameter bit          LZB      = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] D_IN,
  input  logic        LOAD,
  output logic [3:0]  NIB,
  output logic [3:0]  SA,
  output logic        FRAME,
  output logic        PEND
);

  slot_state_t state_nxt;
  dig_idx_t    idx_nxt;
  logic        frame_end;

  logic [15:0] val;
  logic [15:0] pval;
  logic [15:0] val_nxt;
  logic [3:0]  nib_nxt;
  logic [3:0]  sel;
  logic [3:0]  sel_nxt;

  led7seg_scan_slot_timer #(
    .SLOT_CYC (SLOT_CYC),
    .GAP_CYC  (GAP_CYC)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST_N),
    .state_nxt (state_nxt),
    .idx_nxt   (idx_nxt),
    .frame_end (frame_end)
  );

  // Output registers are fed from the timer's next-state so NIB/SA line up
  // with the cycle the timer actually occupies.
  always_comb begin
    val_nxt = (frame_end && PEND) ? pval : val;
    case (idx_nxt)
      2'd1:    nib_nxt = val_nxt[7:4];
      2'd2:    nib_nxt = val_nxt[11:8];
      2'd3:    nib_nxt = val_nxt[15:12];
      default: nib_nxt = val_nxt[3:0];
    endcase
    sel_nxt = '0;
    if (state_nxt == ST_SHOW && digit_lit(val_nxt, idx_nxt, LZB))
      sel_nxt[idx_nxt] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      val   <= '0;
      pval  <= '0;
      PEND  <= 1'b0;
      NIB   <= '0;
      sel   <= '0;
      FRAME <= 1'b0;
    end else begin
      val   <= val_nxt;
      NIB   <= nib_nxt;
      sel   <= sel_nxt;
      FRAME <= frame_end;
      if (LOAD) begin
        pval <= D_IN;
        PEND <= 1'b1;
      end else if (frame_end) begin
        PEND <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_sa
    assign SA[g] = sel[g] ? 1'b0 : SA_OFF[g];
  end

endmodule
